// File: rtl/oric_sram_arbiter.sv
// Slot sequencer for the shared Oric system SRAM: VIDA/VIDB/CPU/LDR slots per machine cycle.
// Define ORIC_SRAM_LDR_STEAL_EN to let a pending loader write use an unclaimed CPU slot.
module oric_sram_arbiter #(
  parameter int unsigned CYCLE_LEN = 24
) (
  input  logic        CLK_IN,
  input  logic        RESET,
  input  logic        cycle_start,
  input  logic [15:0] vid_addr,
  output logic [7:0]  vid_q,
  output logic [1:0]  vid_stb,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  output logic [7:0]  cpu_rdata,
  output logic        cpu_ack,
  input  logic        ldr_req,
  input  logic [15:0] ldr_addr,
  input  logic [7:0]  ldr_wdata,
  output logic        ldr_ack,
  output logic [15:0] ram_ad,
  output logic [7:0]  ram_d,
  input  logic [7:0]  ram_q,
  output logic        ram_cs,
  output logic        ram_oe,
  output logic        ram_we
);

  localparam int unsigned CNT_W = $clog2(CYCLE_LEN);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CYCLE_LEN - 1);
  localparam logic [CNT_W-1:0] SLOT_VIDA = CNT_W'(0);
  localparam logic [CNT_W-1:0] SLOT_VIDB = CNT_W'(4);
  localparam logic [CNT_W-1:0] SLOT_CPU  = CNT_W'(12);
  localparam logic [CNT_W-1:0] SLOT_LDR  = CNT_W'(18);

  typedef enum logic [2:0] {
    ACC_IDLE,
    ACC_VIDA,
    ACC_VIDB,
    ACC_CPU_RD,
    ACC_CPU_WR,
    ACC_LDR_WR
  } acc_t;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  acc_t             acc_q, acc_d;
  logic [1:0]       off_q, off_d;
  logic [15:0]      addr_q, addr_d;
  logic [7:0]       wdata_q, wdata_d;
  logic [7:0]       vid_data_q, vid_data_d;
  logic [1:0]       vid_stb_q, vid_stb_d;
  logic [7:0]       cpu_rdata_q, cpu_rdata_d;
  logic             cpu_ack_q, cpu_ack_d;
  logic             ldr_ack_q, ldr_ack_d;
  logic             ram_cs_q, ram_cs_d;
  logic             ram_oe_q, ram_oe_d;
  logic             ram_we_q, ram_we_d;
  logic             acc_done;

  always_comb begin
    cnt_d       = cnt_q;
    acc_d       = ACC_IDLE;
    off_d       = '0;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    vid_data_d  = vid_data_q;
    vid_stb_d   = '0;
    cpu_rdata_d = cpu_rdata_q;
    cpu_ack_d   = 1'b0;
    ldr_ack_d   = 1'b0;
    acc_done    = 1'b0;

    if (cycle_start) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_LAST) begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    // A cycle_start anywhere inside a slot kills the access: no continuation, no completion.
    if (acc_q != ACC_IDLE && !cycle_start) begin
      if (off_q == 2'd3) begin
        acc_done = 1'b1;
      end else begin
        acc_d = acc_q;
        off_d = 2'(off_q + 2'd1);
      end
    end

    if (acc_done) begin
      case (acc_q)
        ACC_VIDA: begin
          vid_data_d = ram_q;
          vid_stb_d  = 2'b01;
        end
        ACC_VIDB: begin
          vid_data_d = ram_q;
          vid_stb_d  = 2'b10;
        end
        ACC_CPU_RD: begin
          cpu_rdata_d = ram_q;
          cpu_ack_d   = 1'b1;
        end
        ACC_CPU_WR: cpu_ack_d = 1'b1;
        ACC_LDR_WR: ldr_ack_d = 1'b1;
        default: ;
      endcase
    end

    // Slot start: the holding registers capture the requester's inputs on the edge entering offset 0.
    if (cycle_start || cnt_q != CNT_LAST) begin
      case (cnt_d)
        SLOT_VIDA: begin
          acc_d  = ACC_VIDA;
          off_d  = '0;
          addr_d = vid_addr;
        end
        SLOT_VIDB: begin
          acc_d  = ACC_VIDB;
          off_d  = '0;
          addr_d = vid_addr;
        end
        SLOT_CPU: begin
          off_d = '0;
          if (cpu_req) begin
            acc_d   = cpu_we ? ACC_CPU_WR : ACC_CPU_RD;
            addr_d  = cpu_addr;
            wdata_d = cpu_wdata;
`ifdef ORIC_SRAM_LDR_STEAL_EN
          end else if (ldr_req) begin
            acc_d   = ACC_LDR_WR;
            addr_d  = ldr_addr;
            wdata_d = ldr_wdata;
`endif
          end else begin
            acc_d = ACC_IDLE;
          end
        end
        SLOT_LDR: begin
          off_d = '0;
          if (ldr_req) begin
            acc_d   = ACC_LDR_WR;
            addr_d  = ldr_addr;
            wdata_d = ldr_wdata;
          end else begin
            acc_d = ACC_IDLE;
          end
        end
        default: ;
      endcase
    end

    ram_cs_d = (acc_d != ACC_IDLE);
    ram_oe_d = (acc_d == ACC_VIDA) || (acc_d == ACC_VIDB) || (acc_d == ACC_CPU_RD);
    ram_we_d = ((acc_d == ACC_CPU_WR) || (acc_d == ACC_LDR_WR))
               && ((off_d == 2'd1) || (off_d == 2'd2));
  end

  always_ff @(posedge CLK_IN) begin
    if (RESET) begin
      cnt_q       <= CNT_LAST;
      acc_q       <= ACC_IDLE;
      off_q       <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      vid_data_q  <= '0;
      vid_stb_q   <= '0;
      cpu_rdata_q <= '0;
      cpu_ack_q   <= 1'b0;
      ldr_ack_q   <= 1'b0;
      ram_cs_q    <= 1'b0;
      ram_oe_q    <= 1'b0;
      ram_we_q    <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      off_q       <= off_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      vid_data_q  <= vid_data_d;
      vid_stb_q   <= vid_stb_d;
      cpu_rdata_q <= cpu_rdata_d;
      cpu_ack_q   <= cpu_ack_d;
      ldr_ack_q   <= ldr_ack_d;
      ram_cs_q    <= ram_cs_d;
      ram_oe_q    <= ram_oe_d;
      ram_we_q    <= ram_we_d;
    end
  end

  assign vid_q     = vid_data_q;
  assign vid_stb   = vid_stb_q;
  assign cpu_rdata = cpu_rdata_q;
  assign cpu_ack   = cpu_ack_q;
  assign ldr_ack   = ldr_ack_q;
  assign ram_ad    = addr_q;
  assign ram_d     = wdata_q;
  assign ram_cs    = ram_cs_q;
  assign ram_oe    = ram_oe_q;
  assign ram_we    = ram_we_q;

endmodule

// File: tb/tb_oric_sram_arbiter.sv
// Scoreboard bench for oric_sram_arbiter: directed machine cycles against an async SRAM model.
// Loader-ack timing follows ORIC_SRAM_LDR_STEAL_EN when that macro is defined for the build.
module tb_oric_sram_arbiter;

  localparam int CYCLE_LEN = 24;
  localparam int LAST      = CYCLE_LEN - 1;
`ifdef ORIC_SRAM_LDR_STEAL_EN
  localparam int LDR_IDLE_ACK_CNT = 16;
`else
  localparam int LDR_IDLE_ACK_CNT = 22;
`endif

  logic        CLK_IN = 1'b0;
  logic        RESET;
  logic        cycle_start;
  logic [15:0] vid_addr;
  logic [7:0]  vid_q;
  logic [1:0]  vid_stb;
  logic        cpu_req;
  logic        cpu_we;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic [7:0]  cpu_rdata;
  logic        cpu_ack;
  logic        ldr_req;
  logic [15:0] ldr_addr;
  logic [7:0]  ldr_wdata;
  logic        ldr_ack;
  logic [15:0] ram_ad;
  logic [7:0]  ram_d;
  logic [7:0]  ram_q;
  logic        ram_cs;
  logic        ram_oe;
  logic        ram_we;

  oric_sram_arbiter #(.CYCLE_LEN(CYCLE_LEN)) dut (
    .CLK_IN      (CLK_IN),
    .RESET       (RESET),
    .cycle_start (cycle_start),
    .vid_addr    (vid_addr),
    .vid_q       (vid_q),
    .vid_stb     (vid_stb),
    .cpu_req     (cpu_req),
    .cpu_we      (cpu_we),
    .cpu_addr    (cpu_addr),
    .cpu_wdata   (cpu_wdata),
    .cpu_rdata   (cpu_rdata),
    .cpu_ack     (cpu_ack),
    .ldr_req     (ldr_req),
    .ldr_addr    (ldr_addr),
    .ldr_wdata   (ldr_wdata),
    .ldr_ack     (ldr_ack),
    .ram_ad      (ram_ad),
    .ram_d       (ram_d),
    .ram_q       (ram_q),
    .ram_cs      (ram_cs),
    .ram_oe      (ram_oe),
    .ram_we      (ram_we)
  );

  always #5 CLK_IN = ~CLK_IN;

  // Asynchronous SRAM: read data follows the address while selected, write on the clock.
  logic [7:0] mem [0:65535];
  assign ram_q = (ram_cs && ram_oe) ? mem[ram_ad] : 8'h00;
  always @(posedge CLK_IN) begin
    if (ram_cs && ram_we) mem[ram_ad] <= ram_d;
  end

  typedef struct {
    logic [1:0] stb;
    logic [7:0] data;
    int         cnt;
  } exp_t;

  exp_t vid_exp[$];
  exp_t cpu_exp[$];
  exp_t ldr_exp[$];

  int n_checks = 0;
  int n_fail   = 0;
  int tb_cnt   = LAST;
  bit mon_en   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic unexpected(input string name, input logic [31:0] act);
    n_checks++;
    n_fail++;
    $display("FAIL %s: strobe %0h with no response expected (cnt=%0d, t=%0t)", name, act, tb_cnt, $time);
  endtask

  // Advance one clock; the reference count follows the slot-counter rules, and the loader
  // drops its request in the clock after it sees its ack.
  task automatic step();
    bit ack_prev;
    ack_prev = ldr_ack;
    @(posedge CLK_IN);
    if (RESET) tb_cnt = LAST;
    else if (cycle_start) tb_cnt = 0;
    else if (tb_cnt != LAST) tb_cnt++;
    #1;
    if (ack_prev) ldr_req = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ram_cs"}, 32'(ram_cs), 32'd0);
    check({tag, "_ram_oe"}, 32'(ram_oe), 32'd0);
    check({tag, "_ram_we"}, 32'(ram_we), 32'd0);
    check({tag, "_ram_ad"}, 32'(ram_ad), 32'd0);
    check({tag, "_ram_d"}, 32'(ram_d), 32'd0);
    check({tag, "_vid_q"}, 32'(vid_q), 32'd0);
    check({tag, "_vid_stb"}, 32'(vid_stb), 32'd0);
    check({tag, "_cpu_rdata"}, 32'(cpu_rdata), 32'd0);
    check({tag, "_cpu_ack"}, 32'(cpu_ack), 32'd0);
    check({tag, "_ldr_ack"}, 32'(ldr_ack), 32'd0);
  endtask

  // One machine cycle, started by a cycle_start pulse in the current clock. Returns in the
  // last clock of the cycle, or at abort_at with cycle_start about to be re-issued.
  task automatic run_cycle(input bit c_req, input bit c_we, input logic [15:0] c_addr,
                           input logic [7:0] c_wdata, input logic [7:0] c_exp_rdata,
                           input int abort_at, input int reset_at);
    exp_t e;
    bit   cpu_wr_this = 1'b0;
    bit   steal_this  = 1'b0;
    bit   ldr_wr_this = 1'b0;
    bit   exp_we;
    cycle_start = 1'b1;
    vid_addr    = 16'hBB80;
    e.stb = 2'b01; e.data = 8'h41; e.cnt = 4; vid_exp.push_back(e);
    e.stb = 2'b10; e.data = 8'h42; e.cnt = 8; vid_exp.push_back(e);
    step();
    cycle_start = 1'b0;
    for (int i = 0; i < CYCLE_LEN; i++) begin
      case (tb_cnt)
        2: vid_addr = 16'hBB81;
        10: begin
          cpu_req = c_req; cpu_we = c_we; cpu_addr = c_addr; cpu_wdata = c_wdata;
          if (c_req && reset_at < 0) begin
            e.stb = 2'b00; e.data = c_exp_rdata; e.cnt = 16; cpu_exp.push_back(e);
          end
        end
        11: begin
          cpu_wr_this = c_req && c_we;
`ifdef ORIC_SRAM_LDR_STEAL_EN
          steal_this = !c_req && ldr_req;
`endif
        end
        13: begin
          cpu_we = ~c_we; cpu_addr = 16'hFFFF; cpu_wdata = ~c_wdata;
        end
        17: begin
          cpu_req = 1'b0;
          ldr_wr_this = ldr_req;
        end
        default: ;
      endcase
      exp_we = ((tb_cnt == 13 || tb_cnt == 14) && (cpu_wr_this || steal_this))
               || ((tb_cnt == 19 || tb_cnt == 20) && ldr_wr_this);
      check("ram_we", 32'(ram_we), 32'(exp_we));
      if ((tb_cnt == 13 || tb_cnt == 14) && cpu_wr_this) begin
        check("cpu_wr_ram_ad", 32'(ram_ad), 32'(c_addr));
        check("cpu_wr_ram_d", 32'(ram_d), 32'(c_wdata));
      end
      if ((tb_cnt == 13 || tb_cnt == 14) && steal_this) begin
        check("steal_ram_ad", 32'(ram_ad), 32'(ldr_addr));
        check("steal_ram_d", 32'(ram_d), 32'(ldr_wdata));
      end
      if (tb_cnt == 19 && ldr_wr_this) begin
        check("ldr_ram_ad", 32'(ram_ad), 32'(ldr_addr));
        check("ldr_ram_d", 32'(ram_d), 32'(ldr_wdata));
      end
      if (tb_cnt == reset_at) begin
        RESET = 1'b1;
        step();
        RESET = 1'b0;
        check_all_zero("midrst");
        return;
      end
      if (tb_cnt == abort_at || tb_cnt == LAST) return;
      step();
    end
  endtask

  always @(negedge CLK_IN) begin
    exp_t e;
    if (mon_en) begin
      if (vid_stb != 2'b00) begin
        if (vid_exp.size() == 0) unexpected("vid_stb", 32'(vid_stb));
        else begin
          e = vid_exp.pop_front();
          check("vid_stb", 32'(vid_stb), 32'(e.stb));
          check("vid_q", 32'(vid_q), 32'(e.data));
          check("vid_cnt", 32'(tb_cnt), 32'(e.cnt));
        end
      end
      if (cpu_ack) begin
        if (cpu_exp.size() == 0) unexpected("cpu_ack", 32'(cpu_ack));
        else begin
          e = cpu_exp.pop_front();
          check("cpu_rdata", 32'(cpu_rdata), 32'(e.data));
          check("cpu_ack_cnt", 32'(tb_cnt), 32'(e.cnt));
        end
      end
      if (ldr_ack) begin
        if (ldr_exp.size() == 0) unexpected("ldr_ack", 32'(ldr_ack));
        else begin
          e = ldr_exp.pop_front();
          check("ldr_ack_cnt", 32'(tb_cnt), 32'(e.cnt));
        end
      end
    end
  end

  task automatic start_loader(input logic [15:0] a, input logic [7:0] d, input int ack_cnt);
    exp_t e;
    ldr_addr  = a;
    ldr_wdata = d;
    ldr_req   = 1'b1;
    e.stb = 2'b00; e.data = 8'h00; e.cnt = ack_cnt;
    ldr_exp.push_back(e);
  endtask

  initial begin
    mem[16'hBB80] = 8'h41;
    mem[16'hBB81] = 8'h42;
    mem[16'h0400] = 8'h00;
    mem[16'h0501] = 8'h00;
    mem[16'h0502] = 8'h00;
    mem[16'h0503] = 8'h00;
    RESET = 1'b1; cycle_start = 1'b0; vid_addr = 16'h1234;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 16'h0; cpu_wdata = 8'h0;
    ldr_req = 1'b0; ldr_addr = 16'h0; ldr_wdata = 8'h0;
    step();
    step();
    cycle_start = 1'b1;
    step();
    RESET = 1'b0;
    cycle_start = 1'b0;
    check_all_zero("rst");
    mon_en = 1'b1;
    // RESET beat cycle_start, so the counter sits idle with the RAM deselected.
    repeat (5) begin
      step();
      check("idle_cs", 32'(ram_cs), 32'd0);
    end

    run_cycle(1'b0, 1'b0, 16'h0000, 8'h00, 8'h00, -1, -1);
    run_cycle(1'b0, 1'b0, 16'h0000, 8'h00, 8'h00, -1, -1);

    run_cycle(1'b1, 1'b1, 16'h0400, 8'h5A, 8'h00, -1, -1);
    run_cycle(1'b1, 1'b0, 16'h0400, 8'h00, 8'h5A, -1, -1);

    start_loader(16'h0501, 8'h77, 22);
    run_cycle(1'b1, 1'b0, 16'h0400, 8'h00, 8'h5A, -1, -1);
    run_cycle(1'b1, 1'b0, 16'h0400, 8'h00, 8'h5A, -1, -1);
    check("sram_0501", 32'(mem[16'h0501]), 32'h77);

    start_loader(16'h0502, 8'h33, LDR_IDLE_ACK_CNT);
    run_cycle(1'b0, 1'b0, 16'h0000, 8'h00, 8'h00, -1, -1);
    run_cycle(1'b0, 1'b0, 16'h0000, 8'h00, 8'h00, -1, -1);
    check("sram_0502", 32'(mem[16'h0502]), 32'h33);

    start_loader(16'h0503, 8'h99, 22);
    run_cycle(1'b1, 1'b0, 16'h0400, 8'h00, 8'h5A, 20, -1);
    run_cycle(1'b1, 1'b0, 16'h0400, 8'h00, 8'h5A, -1, -1);
    check("sram_0503", 32'(mem[16'h0503]), 32'h99);

    run_cycle(1'b1, 1'b0, 16'h0400, 8'h00, 8'h00, -1, 13);
    repeat (30) begin
      step();
      check("post_rst_cs", 32'(ram_cs), 32'd0);
    end

    run_cycle(1'b1, 1'b0, 16'h0400, 8'h00, 8'h5A, -1, -1);
    repeat (3) step();

    check("vid_pending", 32'(vid_exp.size()), 32'd0);
    check("cpu_pending", 32'(cpu_exp.size()), 32'd0);
    check("ldr_pending", 32'(ldr_exp.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/oric_sram_arbiter.md
# oric_sram_arbiter

Time-slot arbiter and sequencer for the single-port system SRAM shared by the ULA video fetcher, the 6502 CPU and a host-side loader (tape/image injection). Each 1 MHz machine cycle is divided into fixed access slots that drive `ram_ad/ram_d/ram_cs/ram_oe/ram_we` directly. Each requester gets its read data or a completion strobe at a fixed, cycle-exact point. The block sits between the ULA/CPU address paths and the external SRAM port.

## Interface
- `CYCLE_LEN`, 24: CLK_IN clocks per machine cycle; minimum 24.
- `CLK_IN` in 1: system clock; the only clock.
- `RESET` in 1: synchronous, active-high reset.
- `cycle_start` in 1: one-clock pulse marking machine-cycle start (ULA PHI2_EN).
- `vid_addr` in 16: video fetch address; sampled at cnt=0 (fetch A) and cnt=4 (fetch B).
- `vid_q` out 8: video read data.
- `vid_stb` out 2: bit0 pulses when fetch A data is valid, bit1 pulses when fetch B data is valid.
- `cpu_req` in 1: CPU RAM access this cycle (CSRAMn decoded, active-high).
- `cpu_we` in 1: 1 = write.
- `cpu_addr` in 16: CPU address.
- `cpu_wdata` in 8: CPU write data.
- `cpu_rdata` out 8: CPU read data.
- `cpu_ack` out 1: one-clock completion pulse for the CPU access.
- `ldr_req` in 1: loader write request; level, held until `ldr_ack`.
- `ldr_addr` in 16: loader write address.
- `ldr_wdata` in 8: loader write data.
- `ldr_ack` out 1: one-clock pulse when the loader write is complete.
- `ram_ad` out 16: SRAM address.
- `ram_d` out 8: SRAM write data.
- `ram_q` in 8: SRAM read data.
- `ram_cs` out 1: SRAM chip select.
- `ram_oe` out 1: SRAM output enable.
- `ram_we` out 1: SRAM write enable.

## Operation
- Slot counter `cnt`, range 0..CYCLE_LEN-1:
  - Cleared to 0 on `cycle_start`; otherwise increments.
  - Saturates at CYCLE_LEN-1 (idle) if no `cycle_start` arrives.
- Slots are 4 clocks each (offsets 0..3 within the slot):
  - VIDA at cnt 0–3.
  - VIDB at cnt 4–7.
  - CPU at cnt 12–15.
  - LDR at cnt 18–21.
  - All other counts are idle: `ram_cs/oe/we` = 0.
- Slot-start sampling (offset 0):
  - Address, direction and write data are sampled into holding registers.
  - `ram_ad/ram_d` are driven from those registers for the whole slot.
- Read access:
  - `ram_cs`=`ram_oe`=1 for offsets 0–3.
  - `ram_q` is registered at the end of offset 3.
- Write access:
  - `ram_cs`=1 for offsets 0–3, `ram_we`=1 for offsets 1–2, `ram_oe`=0.
- VIDA/VIDB: always reads.
- CPU slot:
  - Used only if `cpu_req`=1 at cnt=12.
  - Later changes to `cpu_req`, `cpu_we`, `cpu_addr` or `cpu_wdata` within the cycle are ignored.
  - If unused, the slot is idle or stolen (see Configuration).
- LDR slot:
  - Writes `ldr_addr/ldr_wdata` if `ldr_req`=1 at cnt=18, then pulses `ldr_ack`.
  - At most one loader write per slot.
- `cycle_start` mid-slot:
  - Counter restarts and the current access is aborted: strobes drop on the next clock.
  - No ack or stb is issued for the aborted access.
  - An aborted loader write remains pending and is retried.
- `RESET`:
  - `cnt`=CYCLE_LEN-1.
  - All `ram_*`, `vid_q`, `vid_stb`, `cpu_rdata`, `cpu_ack`, `ldr_ack` = 0.
  - Holding registers = 0.
  - In-flight access dropped without ack.
  - `cycle_start` in the same clock as `RESET`: `RESET` wins.

## Timing
- Counts below are `cnt` values during the clock in which an output is high.
- Video: `vid_stb[0]` and `vid_q` valid at cnt=4; `vid_stb[1]` and `vid_q` valid at cnt=8. `vid_q` holds until the next stb.
- CPU read: `cpu_ack` at cnt=16, `cpu_rdata` valid from cnt=16 until the next CPU read ack.
- CPU write: `cpu_ack` at cnt=16, `cpu_rdata` unchanged.
- Loader: `ldr_ack` at cnt=22. The requester may change `ldr_addr/ldr_wdata` from the clock after the ack.
- Latency from slot start to data or ack: 4 clocks.

## Configuration
- `ORIC_SRAM_LDR_STEAL_EN` defined: if `cpu_req`=0 and `ldr_req`=1 at cnt=12, the CPU slot performs the loader write and pulses `ldr_ack` at cnt=16. The LDR slot in the same cycle then serves the next pending request, if any.
- Undefined: loader writes occur only in the LDR slot. An unused CPU slot stays idle.

## Test plan
- Reset, then `cycle_start` every 24 clocks with `vid_addr`=0xBB80 at cnt 0 and 0xBB81 at cnt 4 (SRAM preloaded 0x41/0x42) -> `vid_stb[0]` at cnt 4 with `vid_q`=0x41, `vid_stb[1]` at cnt 8 with `vid_q`=0x42, `ram_we` never high.
- CPU write 0x5A to 0x0400, then CPU read 0x0400 in the next cycle -> `ram_we` high at cnt 13–14 with `ram_ad`=0x0400 and `ram_d`=0x5A; `cpu_ack` at cnt 16 in both cycles; `cpu_rdata`=0x5A.
- `ldr_req` held with addr 0x0501 and data 0x77, `cpu_req` busy every cycle -> exactly one `ldr_ack` at cnt 22; SRAM[0x0501]=0x77.
- `ldr_req` high with `cpu_req`=0 -> with `ORIC_SRAM_LDR_STEAL_EN` defined, `ldr_ack` at cnt 16; without it, `ldr_ack` at cnt 22.
- `cycle_start` at cnt 20 during a loader write -> no `ldr_ack`, strobes low next clock, write retried and acked at cnt 22 of the following cycle.
- `RESET` asserted at cnt 13 during a CPU read -> all outputs 0 next clock, no `cpu_ack`, `cnt` idle until `cycle_start`.
